// File: rtl/qcnot_pkg.sv
// qcnot_pkg: shared op codes, FSM states and the fan-out CNOT primitive
package qcnot_pkg;
  localparam int MAXW = 32;
  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_APPLY  = 2'b01,
    OP_UNDO   = 2'b10,
    OP_REWIND = 2'b11
  } op_e;
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_REWIND = 1'b1
  } fsm_e;
  // Keep bit c, XOR every other bit with bit c; applying it twice is the identity
  function automatic logic [MAXW-1:0] fanout_cnot(input logic [MAXW-1:0] s, input logic [4:0] c);
    return s ^ ({MAXW{s[c]}} & ~(MAXW'(1) << c));
  endfunction
endpackage

// File: rtl/qcnot_hist_stack.sv
// qcnot_hist_stack: LIFO of control indices recording applied CNOT steps
module qcnot_hist_stack
  import qcnot_pkg::*;
#(
  parameter int DW    = 3,
  parameter int DEPTH = 8,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [DW-1:0]   data_i,
  output logic [DW-1:0]   top_o,
  output logic [CNTW-1:0] depth_o,
  output logic            full_o,
  output logic            empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [CNTW-1:0] depth_q, depth_d;
  logic [AW-1:0]   wr_idx, rd_idx;
  assign full_o  = depth_q == CNTW'(DEPTH);
  assign empty_o = depth_q == '0;
  assign depth_o = depth_q;
  assign wr_idx  = AW'(depth_q);
  assign rd_idx  = AW'(depth_q - 1'b1);
  assign top_o   = empty_o ? '0 : mem_q[rd_idx];
  // Pointer next state: clear beats push beats pop; full/empty guard the ends
  always_comb begin
    depth_d = clear_i             ? '0 :
              push_i && !full_o   ? depth_q + 1'b1 :
              pop_i  && !empty_o  ? depth_q - 1'b1 : depth_q;
  end
  // Depth counter, lost on reset together with the history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) depth_q <= '0;
    else     depth_q <= depth_d;
  end
  // Entry storage needs no reset: only slots below depth are ever read
  always_ff @(posedge clk) begin
    if (push_i && !full_o && !clear_i) mem_q[wr_idx] <= data_i;
  end
endmodule

// File: rtl/qcnot_undo_engine.sv
// qcnot_undo_engine: reversible state register with CNOT history, undo and rewind
module qcnot_undo_engine
  import qcnot_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8,
  parameter int IDXW  = $clog2(WIDTH),
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_code,
  input  logic [IDXW-1:0]  op_ctrl,
  output logic [WIDTH-1:0] state_out,
  output logic [CNTW-1:0]  depth_out,
  output logic             busy,
  output logic             done,
  output logic             err_overflow,
  output logic             err_underflow,
  output logic             err_ctrl
);
  fsm_e             fsm_q, fsm_d;
  logic [WIDTH-1:0] word_q, word_d, cnot_w;
  logic             done_q, done_d;
  logic             eov_q, eov_d, eun_q, eun_d, ectl_q, ectl_d;
  logic             push, pop, clear, full, empty, accept, ctrl_bad;
  logic [IDXW-1:0]  top, cnot_idx;
  op_e              op;
  qcnot_hist_stack #(.DW(IDXW), .DEPTH(DEPTH), .CNTW(CNTW)) u_stack (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (op_ctrl),
    .top_o   (top),
    .depth_o (depth_out),
    .full_o  (full),
    .empty_o (empty)
  );
  assign op       = op_e'(op_code);
  assign op_ready = !rst && fsm_q == ST_IDLE && !load_valid;
  assign accept   = op_valid && op_ready;
  assign ctrl_bad = int'(op_ctrl) >= WIDTH;
  assign cnot_idx = (fsm_q == ST_IDLE && op == OP_APPLY) ? op_ctrl : top;
  assign cnot_w   = WIDTH'(fanout_cnot(MAXW'(word_q), 5'(cnot_idx)));
  assign state_out     = word_q;
  assign busy          = fsm_q == ST_REWIND;
  assign done          = done_q;
  assign err_overflow  = eov_q;
  assign err_underflow = eun_q;
  assign err_ctrl      = ectl_q;
  // Next state: rewind pops one step per cycle, otherwise load beats commands
  always_comb begin
    fsm_d  = fsm_q;
    word_d = word_q;
    done_d = 1'b0;
    eov_d  = eov_q;
    eun_d  = eun_q;
    ectl_d = ectl_q;
    push   = 1'b0;
    pop    = 1'b0;
    clear  = 1'b0;
    if (fsm_q == ST_REWIND) begin
      pop    = 1'b1;
      word_d = cnot_w;
      if (depth_out == CNTW'(1)) begin
        fsm_d  = ST_IDLE;
        done_d = 1'b1;
      end
    end else if (load_valid) begin
      word_d = load_data;
      clear  = 1'b1;
      eov_d  = 1'b0;
      eun_d  = 1'b0;
      ectl_d = 1'b0;
    end else if (accept) begin
      case (op)
        OP_APPLY: begin
          if (ctrl_bad) ectl_d = 1'b1;
          else if (full) eov_d = 1'b1;
          else begin
            word_d = cnot_w;
            push   = 1'b1;
          end
        end
        OP_UNDO: begin
          if (empty) eun_d = 1'b1;
          else begin
            word_d = cnot_w;
            pop    = 1'b1;
          end
        end
        OP_REWIND: begin
          if (empty) done_d = 1'b1;
          else fsm_d = ST_REWIND;
        end
        default: ;
      endcase
    end
  end
  // Registered engine state; reset aborts any rewind without a done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q  <= ST_IDLE;
      word_q <= '0;
      done_q <= 1'b0;
      eov_q  <= 1'b0;
      eun_q  <= 1'b0;
      ectl_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      word_q <= word_d;
      done_q <= done_d;
      eov_q  <= eov_d;
      eun_q  <= eun_d;
      ectl_q <= ectl_d;
    end
  end
endmodule

// File: tb/tb_qcnot_undo_engine.sv
// tb_qcnot_undo_engine: directed checks of apply, undo, rewind, errors and reset
module tb_qcnot_undo_engine;
  import qcnot_pkg::*;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic [4:0] load_data = '0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [1:0] op_code = OP_NOP;
  logic [2:0] op_ctrl = '0;
  logic [4:0] state_out;
  logic [3:0] depth_out;
  logic       busy, done, err_overflow, err_underflow, err_ctrl;
  int         total = 0;
  int         bad = 0;
  int         nbusy, ndone;
  logic [4:0] st_at_done;
  qcnot_undo_engine dut (
    .clk           (clk),
    .rst           (rst),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_code       (op_code),
    .op_ctrl       (op_ctrl),
    .state_out     (state_out),
    .depth_out     (depth_out),
    .busy          (busy),
    .done          (done),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .err_ctrl      (err_ctrl)
  );
  always #5 clk = ~clk;
  task automatic chk1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask
  task automatic chk_int(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic chk_sd(input string tag, input logic [4:0] es, input logic [3:0] ed);
    total++;
    assert (state_out === es) else begin
      bad++;
      $error("FAIL %s state got=%b exp=%b", tag, state_out, es);
    end
    total++;
    assert (depth_out === ed) else begin
      bad++;
      $error("FAIL %s depth got=%0d exp=%0d", tag, depth_out, ed);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [4:0] d);
    load_valid = 1'b1;
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask
  task automatic op(input logic [1:0] c, input logic [2:0] x);
    op_valid = 1'b1;
    op_code  = c;
    op_ctrl  = x;
    tick();
    op_valid = 1'b0;
    op_code  = OP_NOP;
  endtask
  initial begin
    tick();
    tick();
    chk_sd("reset", 5'b00000, 4'd0);
    chk1("reset_ready", op_ready, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", done, 1'b0);
    chk1("reset_errs", err_overflow | err_underflow | err_ctrl, 1'b0);
    rst = 1'b0;
    #1;
    chk1("idle_ready", op_ready, 1'b1);
    load_valid = 1'b1;
    load_data  = 5'b00001;
    op_valid   = 1'b1;
    op_code    = OP_APPLY;
    op_ctrl    = 3'd0;
    #1;
    chk1("load_blocks_ready", op_ready, 1'b0);
    tick();
    load_valid = 1'b0;
    op_valid   = 1'b0;
    chk_sd("load_priority", 5'b00001, 4'd0);
    op(OP_APPLY, 3'd0);
    chk_sd("apply0", 5'b11111, 4'd1);
    op(OP_APPLY, 3'd1);
    chk_sd("apply1", 5'b00010, 4'd2);
    op(OP_UNDO, 3'd0);
    chk_sd("undo", 5'b11111, 4'd1);
    op(OP_NOP, 3'd3);
    chk_sd("nop", 5'b11111, 4'd1);
    load(5'b10110);
    op(OP_APPLY, 3'd1);
    chk_sd("rw_apply1", 5'b01011, 4'd1);
    op(OP_APPLY, 3'd2);
    op(OP_APPLY, 3'd4);
    chk_sd("rw_apply3", 5'b01011, 4'd3);
    op_valid = 1'b1;
    op_code  = OP_REWIND;
    tick();
    op_valid = 1'b0;
    chk1("rw_ready_low", op_ready, 1'b0);
    nbusy = 0;
    ndone = 0;
    st_at_done = 'x;
    for (int i = 0; i < 6; i++) begin
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        st_at_done = state_out;
      end
      tick();
    end
    chk_int("rw_busy_cycles", nbusy, 3);
    chk_int("rw_done_pulses", ndone, 1);
    chk1("rw_state_at_done", st_at_done === 5'b10110, 1'b1);
    chk_sd("rw_final", 5'b10110, 4'd0);
    op(OP_REWIND, 3'd0);
    chk1("rw_empty_done", done, 1'b1);
    chk1("rw_empty_busy", busy, 1'b0);
    chk_sd("rw_empty_state", 5'b10110, 4'd0);
    tick();
    chk1("rw_empty_done_drop", done, 1'b0);
    load(5'b00000);
    for (int i = 0; i < 8; i++) op(OP_APPLY, 3'd2);
    chk_sd("fill8", 5'b00000, 4'd8);
    chk1("fill8_no_ovf", err_overflow, 1'b0);
    op(OP_APPLY, 3'd2);
    chk1("overflow", err_overflow, 1'b1);
    chk_sd("overflow_hold", 5'b00000, 4'd8);
    load(5'b00111);
    chk1("load_clears_ovf", err_overflow, 1'b0);
    chk_sd("load_after_ovf", 5'b00111, 4'd0);
    op(OP_UNDO, 3'd0);
    chk1("underflow", err_underflow, 1'b1);
    chk_sd("underflow_hold", 5'b00111, 4'd0);
    op(OP_APPLY, 3'd5);
    chk1("err_ctrl", err_ctrl, 1'b1);
    chk_sd("err_ctrl_hold", 5'b00111, 4'd0);
    op(OP_APPLY, 3'd0);
    chk_sd("apply_after_err", 5'b11001, 4'd1);
    chk1("err_ctrl_sticky", err_ctrl, 1'b1);
    chk1("err_under_sticky", err_underflow, 1'b1);
    load(5'b00001);
    chk1("load_clears_errs", err_ctrl | err_underflow, 1'b0);
    op(OP_APPLY, 3'd0);
    op(OP_APPLY, 3'd1);
    op(OP_APPLY, 3'd2);
    op(OP_APPLY, 3'd3);
    chk_sd("pre_abort", 5'b00010, 4'd4);
    op(OP_REWIND, 3'd0);
    chk1("abort_busy1", busy, 1'b1);
    tick();
    chk1("abort_busy2", busy, 1'b1);
    chk_sd("abort_mid", 5'b00010, 4'd3);
    #2;
    rst = 1'b1;
    #1;
    chk_sd("abort_reset", 5'b00000, 4'd0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk1("abort_ready", op_ready, 1'b0);
    tick();
    chk1("abort_done_hold", done, 1'b0);
    rst = 1'b0;
    #1;
    chk1("post_ready", op_ready, 1'b1);
    tick();
    chk1("post_no_done", done, 1'b0);
    chk_sd("post_state", 5'b00000, 4'd0);
    load(5'b00001);
    op(OP_APPLY, 3'd0);
    chk_sd("post_apply", 5'b11111, 4'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/qcnot_undo_engine.md
Name: qcnot_undo_engine

Overview:
- Sequential companion to the 5-bit fan-out CNOT gate; runs the reverse (uncompute) direction of the reversible datapath.
- Holds a WIDTH-bit reversible state register and applies fan-out CNOT steps with a selectable control bit, logging each step on a LIFO history stack.
- Pops the stack to undo the last step, or to rewind the whole history and restore the originally loaded word.
- Serves as the reversible-execution and rollback unit next to the gate-level blocks.

Parameters:
- WIDTH, 5, state width in bits; control index range 0..WIDTH-1.
- DEPTH, 8, history stack entries (maximum outstanding APPLY steps).
- IDXW, $clog2(WIDTH), derived; width of a control index.
- CNTW, $clog2(DEPTH+1), derived; width of the depth counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- load_valid  input  1  load new state word and clear history (IDLE only)
- load_data  input  WIDTH  word to load
- op_valid  input  1  command valid
- op_ready  output  1  engine accepts a command this cycle
- op_code  input  2  00 NOP, 01 APPLY, 10 UNDO, 11 REWIND
- op_ctrl  input  IDXW  control bit index for APPLY
- state_out  output  WIDTH  current state register
- depth_out  output  CNTW  number of stacked steps
- busy  output  1  high while in REWIND
- done  output  1  one-cycle pulse when REWIND completes
- err_overflow  output  1  sticky: APPLY attempted with stack full
- err_underflow  output  1  sticky: UNDO attempted with stack empty
- err_ctrl  output  1  sticky: APPLY with op_ctrl >= WIDTH

Behaviour:
- Fan-out CNOT with control c: s'[c] = s[c]; for every i != c, s'[i] = s[i] ^ s[c]. This operation is self-inverse, so undo re-applies the same c.
- Reset (async, active-high): state_out = 0, depth_out = 0, FSM = IDLE, busy = 0, done = 0, all err flags = 0, op_ready = 0 during reset.
- FSM has two states: IDLE and REWIND.
- In IDLE, op_ready = !load_valid. A command is accepted when op_valid && op_ready.
- Load: load_valid in IDLE writes state = load_data, sets depth = 0 and clears all err flags. Load has priority over a same-cycle command; that command is not accepted. load_valid is ignored in REWIND.
- APPLY: if op_ctrl >= WIDTH, set err_ctrl and leave state and stack unchanged. Else, if depth == DEPTH, set err_overflow and leave everything unchanged. Else apply CNOT(op_ctrl), push op_ctrl, depth += 1.
- UNDO: if depth == 0, set err_underflow and leave state unchanged. Else pop the top index c, apply CNOT(c), depth -= 1.
- REWIND with depth == 0: stay in IDLE, pulse done on the next cycle, no state change.
- REWIND with depth > 0: go to REWIND with busy = 1 and op_ready = 0. Each cycle, pop one entry, apply it and decrement depth. On the cycle depth reaches 0, return to IDLE and raise done for one cycle, coincident with the final state_out. A rewind of N entries takes exactly N cycles after acceptance.
- Latency: all effects are registered and visible on state_out and depth_out the cycle after acceptance.
- NOP is accepted with no effect.
- Error flags stay set until the next load or reset.
- Stack pointer does not wrap; the full and empty checks above are the only guards.
- Reset asserted mid-REWIND aborts it: history is lost, state = 0, no done pulse.

Decomposition:
- Shared package qcnot_pkg holds:
  - the op_code enum (OP_NOP, OP_APPLY, OP_UNDO, OP_REWIND);
  - the FSM state enum;
  - a function fanout_cnot(state, ctrl) reused by the gate-level blocks.
- One sub-module, qcnot_hist_stack: parameterised LIFO with push, pop, top, depth, full and empty.

Test Plan:
- Load 5'b00001, APPLY ctrl 0 → next cycle state_out = 5'b11111, depth_out = 1.
- From there, APPLY ctrl 1 → state_out = 5'b00010, depth 2. Then UNDO → state_out = 5'b11111, depth 1.
- Load 5'b10110, APPLY ctrl 1, 2, 4, then REWIND:
  - busy is high for exactly 3 cycles;
  - done pulses once;
  - state_out = 5'b10110 and depth 0.
- Load 0, 8 × APPLY ctrl 2, then a 9th APPLY → err_overflow = 1, depth 8, state unchanged. Next, load clears err_overflow.
- UNDO on empty → err_underflow = 1, state unchanged. APPLY ctrl 5 → err_ctrl = 1, state unchanged.
- Start REWIND of 4 entries, assert rst on the 2nd busy cycle → all outputs return to 0 immediately, no done pulse. After release, op_ready = 1 in IDLE.
